// File: rtl/interp_pkg.sv
// Shared types for the hash-encoding interpolation group and its result collector:
// collector state encoding, default level/feature geometry and the feature word type.
package interp_pkg;

  localparam int DEF_DATA_SIZE = 32;
  localparam int DEF_NUM_LEVEL = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_OUTPUT  = 2'd2
  } collect_state_t;

  typedef logic [DEF_DATA_SIZE-1:0] feat_word_t;

endpackage

// File: rtl/interp_result_collector.sv
// Gathers per-level interpolated features for one sample point and hands the packed vector
// to the MLP. Optional COLLECT watchdog is enabled with `define INTERP_COLLECT_TIMEOUT_EN.
module interp_result_collector
  import interp_pkg::*;
#(
  parameter int DATA_SIZE      = DEF_DATA_SIZE,
  parameter int NUM_LEVEL      = DEF_NUM_LEVEL,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [NUM_LEVEL-1:0] level_mask,
  input  logic [NUM_LEVEL-1:0] lvl_done,
  input  logic [DATA_SIZE-1:0] lvl_feat [NUM_LEVEL],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_feat [NUM_LEVEL],
  output logic                 busy,
  output logic                 dup_err,
  output logic                 timeout_err,
  input  logic                 err_clr,
  output collect_state_t       dbg_state
);

  // Handshake: out_valid rises once all masked levels are in and stays high with out_feat
  // frozen until the cycle out_valid & out_ready are both high; that cycle is the transfer.

  collect_state_t         state;
  logic [NUM_LEVEL-1:0]   pend;
  logic [NUM_LEVEL-1:0]   got;
  logic [NUM_LEVEL-1:0]   cap_vec;
  logic [NUM_LEVEL-1:0]   err_vec;
  logic [DATA_SIZE-1:0]   feat_q [NUM_LEVEL];
  logic                   accept_start;
  logic                   all_done;
  logic                   timeout_hit;

  assign dbg_state = state;

  always_comb begin
    accept_start = (state == ST_IDLE) && start && (|level_mask);
    cap_vec      = '0;
    err_vec      = lvl_done;
    if (state == ST_COLLECT) begin
      cap_vec = lvl_done & pend & ~got;
      err_vec = lvl_done & ~(pend & ~got);
    end
    all_done = ((got | cap_vec) == pend);
  end

`ifdef INTERP_COLLECT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cyc_cnt;

  // Completion in the limit cycle takes priority over the watchdog.
  assign timeout_hit = (state == ST_COLLECT) && !all_done && (cyc_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (accept_start) cyc_cnt <= '0;
      else if (state == ST_COLLECT) cyc_cnt <= cyc_cnt + 1'b1;
      timeout_err <= (timeout_err & ~err_clr) | timeout_hit;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = |TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      pend      <= '0;
      got       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      dup_err   <= 1'b0;
    end else begin
      dup_err <= (dup_err & ~err_clr) | (|err_vec);
      case (state)
        ST_IDLE: begin
          if (accept_start) begin
            state <= ST_COLLECT;
            pend  <= level_mask;
            got   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_COLLECT: begin
          got <= got | cap_vec;
          if (all_done || timeout_hit) begin
            state     <= ST_OUTPUT;
            out_valid <= 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Buffers clear on each new point so unmasked or timed-out levels read as zero.
  for (genvar i = 0; i < NUM_LEVEL; i++) begin : g_lvl
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)             feat_q[i] <= '0;
      else if (accept_start) feat_q[i] <= '0;
      else if (cap_vec[i])   feat_q[i] <= lvl_feat[i];
    end
    assign out_feat[i] = feat_q[i];
  end

endmodule
